// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, constants and adder helpers for the div block
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 5;
    localparam logic [DIV_W-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Generate/propagate carry chain of the 32-bit CLA adder; sum and carry-out
    // are split so callers that only need one of them leave nothing unused.
    function automatic logic [DIV_W-1:0] cla_sum32(
        input logic [DIV_W-1:0] a,
        input logic [DIV_W-1:0] b,
        input logic             cin
    );
        logic [DIV_W-1:0] g, p, c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 1; i < DIV_W; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        return p ^ c;
    endfunction

    function automatic logic cla_cout32(
        input logic [DIV_W-1:0] a,
        input logic [DIV_W-1:0] b,
        input logic             cin
    );
        logic [DIV_W-1:0] g, p;
        logic [DIV_W:0]   c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 1; i <= DIV_W; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        return c[DIV_W];
    endfunction

    function automatic logic [DIV_W-1:0] negate32(input logic [DIV_W-1:0] x);
        return cla_sum32(~x, '0, 1'b1);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration on magnitudes
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem,
    input  logic [DIV_W-1:0] quo,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_next,
    output logic [DIV_W-1:0] quo_next
);

    logic [DIV_W-1:0] sh_rem;
    logic [DIV_W-1:0] diff;
    logic             no_borrow;

    // The shifted remainder is 33 bits ({rem, quo[31]}); its top bit set means
    // it already exceeds any 32-bit divisor, so the subtract always succeeds.
    always_comb begin
        sh_rem    = {rem[DIV_W-2:0], quo[DIV_W-1]};
        diff      = cla_sum32(sh_rem, ~divisor, 1'b1);
        no_borrow = rem[DIV_W-1] | cla_cout32(sh_rem, ~divisor, 1'b1);
        rem_next  = no_borrow ? diff : sh_rem;
        quo_next  = {quo[DIV_W-2:0], no_borrow};
    end

endmodule

// File: rtl/div.sv
// rtl/div.sv - 32-bit signed sequential divider; DIV_REMAINDER_EN adds data_remainder
module div
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_DIV,
    input  logic [DIV_W-1:0] data_operandA,
    input  logic [DIV_W-1:0] data_operandB,
    output logic [DIV_W-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef DIV_REMAINDER_EN
    ,
    output logic [DIV_W-1:0] data_remainder
`endif
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] rem, quo, divisor;
    logic             neg_q, dz, ovf;
    logic [DIV_W-1:0] abs_a, abs_b, quo_neg, rem_step, quo_step;
`ifdef DIV_REMAINDER_EN
    logic             neg_r;
    logic [DIV_W-1:0] rem_neg;
    assign rem_neg = negate32(rem);
`endif

    always_comb begin
        abs_a   = data_operandA[DIV_W-1] ? negate32(data_operandA) : data_operandA;
        abs_b   = data_operandB[DIV_W-1] ? negate32(data_operandB) : data_operandB;
        quo_neg = negate32(quo);
    end

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // A start in any state (re)launches the op; it is evaluated last so it
    // overrides RUN/DONE transitions while DONE still publishes its result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            rem            <= '0;
            quo            <= '0;
            divisor        <= '0;
            neg_q          <= 1'b0;
            dz             <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef DIV_REMAINDER_EN
            neg_r          <= 1'b0;
            data_remainder <= '0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                RUN: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIV_ITERS - 1)) state <= DONE;
                end
                DONE: begin
                    if (dz)        data_result <= '0;
                    else if (ovf)  data_result <= INT_MIN;
                    else           data_result <= neg_q ? quo_neg : quo;
`ifdef DIV_REMAINDER_EN
                    if (dz || ovf) data_remainder <= '0;
                    else           data_remainder <= neg_r ? rem_neg : rem;
`endif
                    data_exception <= dz | ovf;
                    data_resultRDY <= 1'b1;
                    state          <= IDLE;
                    busy           <= 1'b0;
                end
                default: ;
            endcase
            if (ctrl_DIV) begin
                quo     <= abs_a;
                divisor <= abs_b;
                rem     <= '0;
                cnt     <= '0;
                neg_q   <= data_operandA[DIV_W-1] ^ data_operandB[DIV_W-1];
                dz      <= (data_operandB == '0);
                ovf     <= (data_operandA == INT_MIN) && (data_operandB == '1);
`ifdef DIV_REMAINDER_EN
                neg_r   <= data_operandA[DIV_W-1];
`endif
                state   <= RUN;
                busy    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for div against a plain-arithmetic signed division model
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_DIV;
    logic [31:0] op_a, op_b;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_q = '0;

    div dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
`ifdef DIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] q, output logic [31:0] r, output logic e);
        int sx, sy;
        sx = x;
        sy = y;
        if (y == 32'd0) begin
            q = '0; r = '0; e = 1'b1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0; e = 1'b1;
        end else begin
            q = sx / sy; r = sx % sy; e = 1'b0;
        end
    endtask

    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        ctrl_DIV = 1'b1;
        op_a     = x;
        op_b     = y;
        step();
        ctrl_DIV = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("result_held_on_start", data_result, last_q);
    endtask

    task automatic finish_op(input logic [31:0] x, input logic [31:0] y,
                             input bit chain, input logic [31:0] nx, input logic [31:0] ny);
        logic [31:0] q, r;
        logic        e;
        int          bad_rdy  = 0;
        int          bad_busy = 0;
        ref_div(x, y, q, r, e);
        repeat (32) begin
            step();
            if (data_resultRDY !== 1'b0) bad_rdy++;
            if (busy !== 1'b1) bad_busy++;
        end
        if (chain) begin
            ctrl_DIV = 1'b1;
            op_a     = nx;
            op_b     = ny;
        end
        step();
        ctrl_DIV = 1'b0;
        chk("rdy_during_run", bad_rdy, 0);
        chk("busy_during_run", bad_busy, 0);
        chk("rdy_at_e33", {31'd0, data_resultRDY}, 32'd1);
        chk("quotient", data_result, q);
        chk("exception", {31'd0, data_exception}, {31'd0, e});
`ifdef DIV_REMAINDER_EN
        chk("remainder", data_remainder, r);
`endif
        chk("busy_after_done", {31'd0, busy}, {31'd0, chain});
        last_q = q;
        if (!chain) begin
            step();
            chk("rdy_single_cycle", {31'd0, data_resultRDY}, 32'd0);
        end
    endtask

    initial begin
        int          n_rdy;
        int          n_busy;
        logic [31:0] rx, ry;

        rst      = 1'b1;
        ctrl_DIV = 1'b0;
        op_a     = '0;
        op_b     = '0;
        repeat (2) step();
        rst = 1'b0;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exception", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        start_op(32'd100, 32'd7);              finish_op(32'd100, 32'd7, 1'b0, '0, '0);
        start_op(-32'sd100, 32'd7);            finish_op(-32'sd100, 32'd7, 1'b0, '0, '0);
        start_op(32'd100, -32'sd7);            finish_op(32'd100, -32'sd7, 1'b0, '0, '0);
        start_op(32'd50, 32'd0);               finish_op(32'd50, 32'd0, 1'b1, 32'd9, 32'd3);
        finish_op(32'd9, 32'd3, 1'b0, '0, '0);
        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        finish_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, '0);
        start_op(32'h8000_0000, 32'd1);        finish_op(32'h8000_0000, 32'd1, 1'b0, '0, '0);

        // restart at E10 aborts the first op silently
        start_op(32'd100, 32'd7);
        n_rdy = 0;
        repeat (9) begin
            step();
            if (data_resultRDY !== 1'b0) n_rdy++;
        end
        chk("abort_no_rdy", n_rdy, 0);
        start_op(32'd81, 32'd9);
        finish_op(32'd81, 32'd9, 1'b0, '0, '0);

        // reset mid-run, with a simultaneous start that must lose
        start_op(32'd100, 32'd7);
        repeat (19) step();
        rst      = 1'b1;
        ctrl_DIV = 1'b1;
        step();
        rst      = 1'b0;
        ctrl_DIV = 1'b0;
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_exception", {31'd0, data_exception}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
`ifdef DIV_REMAINDER_EN
        chk("midrst_remainder", data_remainder, 32'd0);
`endif
        n_rdy  = 0;
        n_busy = 0;
        repeat (40) begin
            step();
            if (data_resultRDY !== 1'b0) n_rdy++;
            if (busy !== 1'b0) n_busy++;
        end
        chk("midrst_no_rdy", n_rdy, 0);
        chk("midrst_idle", n_busy, 0);
        last_q = '0;

        for (int i = 0; i < 12; i++) begin
            rx = $urandom;
            if (i % 2 == 0) ry = $urandom;
            else begin
                ry = $urandom_range(1, 300);
                if ($urandom_range(0, 1) == 1) ry = -ry;
            end
            start_op(rx, ry);
            finish_op(rx, ry, 1'b0, '0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
